// File: rtl/reg_incr_nstage_valrdy.sv
// Elastic N-stage registered incrementer with val/rdy handshakes on both sides.
// Each stage adds p_incr (wrapping or saturating) and holds its data while stalled.
module reg_incr_nstage_valrdy #(
   parameter int p_nbits    = 8,
   parameter int p_nstages  = 2,
   parameter int p_incr     = 1,
   parameter int p_saturate = 0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_val,
   output logic                           in_rdy,
   input  logic [p_nbits-1:0]             in_msg,
   output logic                           out_val,
   input  logic                           out_rdy,
   output logic [p_nbits-1:0]             out_msg,
   output logic [$clog2(p_nstages+1)-1:0] occupancy
);

   localparam int occ_w = $clog2(p_nstages+1);
   localparam logic [p_nbits:0] incr_ext = (p_nbits+1)'(p_incr);

   // Handshake: a message moves across an interface on a rising edge where
   // val && rdy; val never waits on rdy, and a stalled stage keeps its message.
   logic [p_nstages:1]   v_q;
   logic [p_nbits-1:0]   d_q  [1:p_nstages];
   logic [p_nstages:1]   v_in;
   logic [p_nbits-1:0]   d_in [1:p_nstages];
   logic [p_nstages+1:1] rdy;

   function automatic logic [p_nbits-1:0] f_incr(input logic [p_nbits-1:0] x);
      logic [p_nbits:0] sum;
      sum = {1'b0, x} + incr_ext;
      if ((p_saturate != 0) && sum[p_nbits])
         f_incr = '1;
      else
         f_incr = sum[p_nbits-1:0];
   endfunction

   always_comb begin
      v_in[1] = in_val;
      d_in[1] = in_msg;
      for (int i = 2; i <= p_nstages; i++) begin
         v_in[i] = v_q[i-1];
         d_in[i] = d_q[i-1];
      end
   end

   // Ready ripples back from the output so an empty stage always accepts.
   always_comb begin
      rdy[p_nstages+1] = out_rdy;
      for (int i = p_nstages; i >= 1; i--)
         rdy[i] = !v_q[i] || rdy[i+1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v_q <= '0;
         for (int i = 1; i <= p_nstages; i++)
            d_q[i] <= '0;
      end else begin
         for (int i = 1; i <= p_nstages; i++) begin
            if (rdy[i]) begin
               v_q[i] <= v_in[i];
               if (v_in[i])
                  d_q[i] <= f_incr(d_in[i]);
            end
         end
      end
   end

   always_comb begin
      occupancy = '0;
      for (int i = 1; i <= p_nstages; i++)
         occupancy = occupancy + occ_w'(v_q[i]);
   end

   assign in_rdy  = rdy[1] && !reset;
   assign out_val = v_q[p_nstages];
   assign out_msg = d_q[p_nstages];

endmodule

// File: tb/tb_reg_incr_nstage_valrdy.sv
// Bench for reg_incr_nstage_valrdy: cycle tables, backpressure/reset sequences,
// wrap/saturate table and a randomized run against a queue model.
module tb_reg_incr_nstage_valrdy;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   int   n_vec = 0;
   int   n_bad = 0;

   // defaults: 8 bits, 2 stages, +1, wrap
   logic       a_in_val, a_in_rdy, a_out_val, a_out_rdy;
   logic [7:0] a_in_msg, a_out_msg;
   logic [1:0] a_occ;

   // 4 bits, 2 stages, +3: b wraps, c saturates (shared inputs)
   logic       bc_in_val, bc_out_rdy, b_in_rdy, c_in_rdy, b_out_val, c_out_val;
   logic [3:0] bc_in_msg, b_out_msg, c_out_msg;
   logic [1:0] b_occ, c_occ;

   // 8 bits, 4 stages, +2, wrap
   logic       d_in_val, d_in_rdy, d_out_val, d_out_rdy;
   logic [7:0] d_in_msg, d_out_msg;
   logic [2:0] d_occ;

   reg_incr_nstage_valrdy #(.p_nbits(8), .p_nstages(2), .p_incr(1), .p_saturate(0)) dut_a (
      .clk(clk), .reset(reset), .in_val(a_in_val), .in_rdy(a_in_rdy), .in_msg(a_in_msg),
      .out_val(a_out_val), .out_rdy(a_out_rdy), .out_msg(a_out_msg), .occupancy(a_occ));

   reg_incr_nstage_valrdy #(.p_nbits(4), .p_nstages(2), .p_incr(3), .p_saturate(0)) dut_b (
      .clk(clk), .reset(reset), .in_val(bc_in_val), .in_rdy(b_in_rdy), .in_msg(bc_in_msg),
      .out_val(b_out_val), .out_rdy(bc_out_rdy), .out_msg(b_out_msg), .occupancy(b_occ));

   reg_incr_nstage_valrdy #(.p_nbits(4), .p_nstages(2), .p_incr(3), .p_saturate(1)) dut_c (
      .clk(clk), .reset(reset), .in_val(bc_in_val), .in_rdy(c_in_rdy), .in_msg(bc_in_msg),
      .out_val(c_out_val), .out_rdy(bc_out_rdy), .out_msg(c_out_msg), .occupancy(c_occ));

   reg_incr_nstage_valrdy #(.p_nbits(8), .p_nstages(4), .p_incr(2), .p_saturate(0)) dut_d (
      .clk(clk), .reset(reset), .in_val(d_in_val), .in_rdy(d_in_rdy), .in_msg(d_in_msg),
      .out_val(d_out_val), .out_rdy(d_out_rdy), .out_msg(d_out_msg), .occupancy(d_occ));

   typedef struct {
      logic       in_val;
      logic [7:0] in_msg;
      logic       out_rdy;
      logic       exp_in_rdy;
      logic       exp_out_val;
      logic [7:0] exp_out_msg;
      logic [1:0] exp_occ;
   } vec_t;

   typedef struct {
      logic [3:0] in_msg;
      logic [3:0] exp_wrap;
      logic [3:0] exp_sat;
   } ws_t;

   vec_t       tbl [16];
   ws_t        ws_tbl [5];
   logic [7:0] exp_q [$];

   function automatic vec_t mk(input logic iv, input logic [7:0] im, input logic ordy,
                               input logic e_rdy, input logic e_val, input logic [7:0] e_msg,
                               input logic [1:0] e_occ);
      vec_t r;
      r.in_val = iv; r.in_msg = im; r.out_rdy = ordy;
      r.exp_in_rdy = e_rdy; r.exp_out_val = e_val; r.exp_out_msg = e_msg; r.exp_occ = e_occ;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int   idx, got;
      logic saw_full, held;
      logic [7:0] held_msg;

      reset = 1'b1;
      a_in_val = 1'b0; a_in_msg = '0; a_out_rdy = 1'b0;
      bc_in_val = 1'b0; bc_in_msg = '0; bc_out_rdy = 1'b0;
      d_in_val = 1'b0; d_in_msg = '0; d_out_rdy = 1'b0;

      // single message 0x05, then a 10-message stream 0x00..0x09 (+2 after 2 stages)
      tbl[0] = mk(1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0);
      tbl[1] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd1);
      tbl[2] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h07, 2'd1);
      tbl[3] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h07, 2'd0);
      for (int j = 0; j < 12; j++)
         tbl[4+j] = mk(j < 10, 8'(j), 1'b1, 1'b1, (j >= 2),
                       (j >= 2) ? 8'(j) : 8'h07,
                       (j == 0) ? 2'd0 : (j == 1) ? 2'd1 : (j <= 10) ? 2'd2 : 2'd1);

      ws_tbl[0] = '{4'hE, 4'h4, 4'hF};
      ws_tbl[1] = '{4'hF, 4'h5, 4'hF};
      ws_tbl[2] = '{4'h9, 4'hF, 4'hF};
      ws_tbl[3] = '{4'hA, 4'h0, 4'hF};
      ws_tbl[4] = '{4'h0, 4'h6, 4'h6};

      tick();
      tick();
      chk("reset in_rdy", a_in_rdy, 0);
      chk("reset out_val", a_out_val, 0);
      chk("reset out_msg", a_out_msg, 0);
      chk("reset occ", a_occ, 0);
      reset = 1'b0;

      for (int k = 0; k < 16; k++) begin
         a_in_val = tbl[k].in_val; a_in_msg = tbl[k].in_msg; a_out_rdy = tbl[k].out_rdy;
         #1;
         chk($sformatf("tbl%0d in_rdy", k), a_in_rdy, tbl[k].exp_in_rdy);
         chk($sformatf("tbl%0d out_val", k), a_out_val, tbl[k].exp_out_val);
         chk($sformatf("tbl%0d out_msg", k), a_out_msg, tbl[k].exp_out_msg);
         chk($sformatf("tbl%0d occ", k), a_occ, tbl[k].exp_occ);
         tick();
      end

      // backpressure: stream 0x10..0x15, downstream stalled in cycles 2..6
      idx = 0; got = 0; saw_full = 1'b0;
      for (int c = 0; c < 40 && got < 6; c++) begin
         a_in_val = (idx < 6); a_in_msg = 8'(8'h10 + idx); a_out_rdy = !(c >= 2 && c <= 6);
         #1;
         chk("bp occ", a_occ, exp_q.size());
         if (a_occ == 2'd2 && !a_out_rdy) begin
            chk("bp in_rdy full", a_in_rdy, 0);
            saw_full = 1'b1;
         end
         if (a_out_val && !a_out_rdy) chk("bp stall msg", a_out_msg, 8'h12);
         if (a_out_val && a_out_rdy) begin
            if (exp_q.size() == 0) chk("bp spurious out_val", a_out_val, 0);
            else chk("bp out_msg", a_out_msg, exp_q.pop_front());
            got++;
         end
         if (a_in_val && a_in_rdy) begin
            exp_q.push_back(8'(a_in_msg + 8'd2));
            idx++;
         end
         tick();
      end
      chk("bp saw full stall", saw_full, 1);
      chk("bp outputs", got, 6);
      chk("bp inputs", idx, 6);
      exp_q.delete();

      // reset with the pipeline full and stalled
      a_in_val = 1'b1; a_in_msg = 8'h40; a_out_rdy = 1'b0;
      tick(); tick(); tick();
      chk("full occ", a_occ, 2);
      chk("full in_rdy", a_in_rdy, 0);
      reset = 1'b1; a_in_msg = 8'h55;
      #1;
      chk("rst in_rdy", a_in_rdy, 0);
      tick();
      reset = 1'b0; a_in_val = 1'b0;
      #1;
      chk("post rst out_val", a_out_val, 0);
      chk("post rst out_msg", a_out_msg, 0);
      chk("post rst occ", a_occ, 0);
      chk("post rst in_rdy", a_in_rdy, 1);
      a_in_val = 1'b1; a_in_msg = 8'h20; a_out_rdy = 1'b1;
      tick();
      a_in_val = 1'b0;
      tick();
      chk("post rst 0x20 val", a_out_val, 1);
      chk("post rst 0x20 msg", a_out_msg, 8'h22);
      tick();

      // wrap vs saturate, 4-bit, +3 per stage, 2 stages
      for (int k = 0; k < 5; k++) begin
         bc_in_val = 1'b1; bc_in_msg = ws_tbl[k].in_msg; bc_out_rdy = 1'b1;
         tick();
         bc_in_val = 1'b0;
         tick();
         chk($sformatf("ws%0d wrap val", k), b_out_val, 1);
         chk($sformatf("ws%0d wrap msg", k), b_out_msg, ws_tbl[k].exp_wrap);
         chk($sformatf("ws%0d sat val", k), c_out_val, 1);
         chk($sformatf("ws%0d sat msg", k), c_out_msg, ws_tbl[k].exp_sat);
      end
      tick();

      // random stress on the 4-stage +2 instance
      held = 1'b0; held_msg = '0;
      for (int c = 0; c < 1000; c++) begin
         d_in_val = 1'($urandom_range(0, 1));
         d_in_msg = 8'($urandom);
         d_out_rdy = (c % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         #1;
         chk("rnd occ", d_occ, exp_q.size());
         chk("rnd in_rdy", d_in_rdy, (exp_q.size() < 4) || d_out_rdy);
         if (held) begin
            chk("rnd hold val", d_out_val, 1);
            chk("rnd hold msg", d_out_msg, held_msg);
         end
         if (d_out_val && d_out_rdy) begin
            if (exp_q.size() == 0) chk("rnd spurious out_val", d_out_val, 0);
            else chk("rnd out_msg", d_out_msg, exp_q.pop_front());
         end
         if (d_in_val && d_in_rdy) exp_q.push_back(8'(d_in_msg + 8'd8));
         held = d_out_val && !d_out_rdy;
         held_msg = d_out_msg;
         tick();
      end
      d_in_val = 1'b0; d_out_rdy = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (d_out_val) begin
            if (exp_q.size() == 0) chk("rnd drain spurious", d_out_val, 0);
            else chk("rnd drain msg", d_out_msg, exp_q.pop_front());
         end
         tick();
      end
      chk("rnd drained", exp_q.size(), 0);
      chk("rnd final occ", d_occ, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
